uart_rx_ctrl: RTL and testbench

- Receive-side sequencer for the UART serial line.
- Synchronises and glitch-filters rx_in, then detects the start bit.
- Times mid-bit sampling with an internal baud counter, assembles the data byte and checks the stop bit.
- Presents each frame through a valid/ready holding register with framing-error and overrun flags. Sits between the pad and the byte-level consumer.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_filter.sv | 40 ++++
 rtl/uart_rx_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART constants, receiver state encoding, clog2 helper
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 10;
    localparam int UART_DATA_BITS    = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE  = ST_IDLE,
        RX_START = ST_START,
        RX_DATA  = ST_DATA,
        RX_STOP  = ST_STOP
    } rx_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_filter.sv
`default_nettype none
// ============================================================================
// uart_rx_filter : rx_in synchroniser, 2-tap OR glitch filter, fall detect
// Revision       : 1.0
// ============================================================================
module uart_rx_filter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic rx_in,
    output logic line,
    output logic fall_edge
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   f1;
    logic                   f2;
    logic                   prev;

    // Everything presets to 1 so a reset never manufactures a start edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
            f1   <= 1'b1;
            f2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_in};
            f1   <= sync[SYNC_STAGES-1];
            f2   <= f1;
            prev <= line;
        end
    end

    assign line      = f1 | f2;
    assign fall_edge = prev & ~line;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// uart_rx_ctrl : UART receive sequencer with valid/ready byte holding register
// Revision     : 1.0
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = clog2(CLKS_PER_BIT);
    localparam int IW = clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

    logic                 line;
    logic                 fall_edge;

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [CW-1:0]        baud_cnt;
    logic [CW-1:0]        baud_nxt;
    logic [IW-1:0]        bit_idx;
    logic [IW-1:0]        idx_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 good_pend;
    logic                 good_nxt;
    logic                 bad_pend;
    logic                 bad_nxt;

    uart_rx_filter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filter (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .line      (line),
        .fall_edge (fall_edge)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            good_pend <= 1'b0;
            bad_pend  <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= idx_nxt;
            shift     <= shift_nxt;
            good_pend <= good_nxt;
            bad_pend  <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift;
        good_nxt  = 1'b0;
        bad_nxt   = 1'b0;
        case (state)
            RX_IDLE: begin
                baud_nxt = '0;
                idx_nxt  = '0;
                if (fall_edge) begin
                    state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_nxt  = '0;
                    idx_nxt   = '0;
                    // Line back high at mid start bit: treat as noise.
                    state_nxt = line ? RX_IDLE : RX_DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    shift_nxt = {line, shift[DATA_BITS-1:1]};
                    if (bit_idx == BIT_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = RX_STOP;
                    end else begin
                        idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = RX_IDLE;
                    good_nxt  = line;
                    bad_nxt   = ~line;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RX_IDLE;
            end
        endcase
    end

    // Holding register: a new byte may replace an unread one only if the
    // consumer takes the old one in that same cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_pend;
            overrun   <= 1'b0;
            if (good_pend) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_ctrl : directed self-checking bench for uart_rx_ctrl
// Revision        : 1.0
// ============================================================================
module tb_uart_rx_ctrl;

    logic       clk_in   = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_in    = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_vec  = 0;
    int n_err  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (10),
        .DATA_BITS    (8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge that ends the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        repeat (10) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (10) @(negedge clk_in);
        end
        rx_in = stop;
        repeat (10) @(negedge clk_in);
        rx_in = 1'b1;
    endtask

    initial begin
        int fe0;
        int ov0;
        int seen;

        // Reset values
        @(negedge clk_in);
        chk("rst_data",  rx_data,   0);
        chk("rst_valid", rx_valid,  0);
        chk("rst_ferr",  frame_err, 0);
        chk("rst_ovr",   overrun,   0);
        chk("rst_busy",  busy,      0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_in);

        // Good frame 0x55
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b1);
        chk("good_valid_early", rx_valid, 0);
        @(negedge clk_in);
        chk("good_valid", rx_valid, 1);
        chk("good_data",  rx_data,  8'h55);
        rx_ready = 1'b1;
        @(negedge clk_in);
        rx_ready = 1'b0;
        chk("good_consume", rx_valid, 0);
        chk("good_no_ferr", fe_cnt - fe0, 0);
        repeat (10) @(negedge clk_in);

        // One-cycle glitch is filtered out
        rx_in = 1'b0;
        @(negedge clk_in);
        rx_in = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (busy) seen = 1;
        end
        chk("glitch_busy", seen, 0);

        // 60 ns pulse: false start
        fe0 = fe_cnt;
        rx_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rx_in = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (busy) seen++;
        end
        chk("false_start_entered", seen > 0, 1);
        chk("false_start_idle",    busy,     0);
        chk("false_start_valid",   rx_valid, 0);
        chk("false_start_ferr",    fe_cnt - fe0, 0);

        // Framing error 0xA3
        fe0 = fe_cnt;
        send_frame(8'hA3, 1'b0);
        chk("ferr_early", frame_err, 0);
        @(negedge clk_in);
        chk("ferr_pulse", frame_err, 1);
        @(negedge clk_in);
        chk("ferr_single", frame_err, 0);
        chk("ferr_count",  fe_cnt - fe0, 1);
        chk("ferr_valid",  rx_valid, 0);
        chk("ferr_data",   rx_data,  8'h55);
        repeat (10) @(negedge clk_in);

        // Line held low (break)
        fe0 = fe_cnt;
        rx_in = 1'b0;
        repeat (150) @(negedge clk_in);
        chk("break_ferr",  fe_cnt - fe0, 1);
        chk("break_busy",  busy,     0);
        chk("break_valid", rx_valid, 0);
        rx_in = 1'b1;
        repeat (20) @(negedge clk_in);

        // Overrun: back-to-back with no consumer
        ov0 = ov_cnt;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        @(negedge clk_in);
        chk("ovr_pulse", overrun,  1);
        chk("ovr_data",  rx_data,  8'h12);
        chk("ovr_valid", rx_valid, 1);
        @(negedge clk_in);
        chk("ovr_single", overrun, 0);
        chk("ovr_count",  ov_cnt - ov0, 1);
        rx_ready = 1'b1;
        @(negedge clk_in);
        rx_ready = 1'b0;
        chk("ovr_drain", rx_valid, 0);
        repeat (10) @(negedge clk_in);

        // Consumer reads on the load cycle: new byte replaces old
        ov0 = ov_cnt;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        rx_ready = 1'b1;
        @(negedge clk_in);
        rx_ready = 1'b0;
        chk("swap_data",  rx_data,  8'h34);
        chk("swap_valid", rx_valid, 1);
        @(negedge clk_in);
        chk("swap_no_ovr", ov_cnt - ov0, 0);
        rx_ready = 1'b1;
        @(negedge clk_in);
        rx_ready = 1'b0;
        repeat (10) @(negedge clk_in);

        // Asynchronous reset with the line toggling
        send_frame(8'h5A, 1'b1);
        repeat (2) @(negedge clk_in);
        chk("pre_rst_data", rx_data, 8'h5A);
        rx_in = 1'b0;
        repeat (25) @(negedge clk_in);
        chk("pre_rst_busy", busy, 1);
        #5 rst_n = 1'b0;
        #1;
        chk("arst_valid", rx_valid, 0);
        chk("arst_data",  rx_data,  0);
        chk("arst_busy",  busy,     0);
        seen = 0;
        repeat (8) begin
            @(negedge clk_in);
            rx_in = ~rx_in;
            if (busy) seen = 1;
        end
        @(negedge clk_in);
        rx_in = 1'b1;
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk_in);
            if (busy) seen = 1;
        end
        chk("arst_busy_hold", seen, 0);

        // Reset during bit 4 of 0xFF, then a clean 0x0F
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx_in = 1'b0;
        repeat (10) @(negedge clk_in);
        rx_in = 1'b1;
        repeat (45) @(negedge clk_in);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_in);
        chk("midrst_busy",  busy,     0);
        chk("midrst_valid", rx_valid, 0);
        send_frame(8'h0F, 1'b1);
        chk("midrst_valid_early", rx_valid, 0);
        @(negedge clk_in);
        chk("midrst_valid_new", rx_valid, 1);
        chk("midrst_data",      rx_data,  8'h0F);
        repeat (5) @(negedge clk_in);
        chk("midrst_ferr", fe_cnt - fe0, 0);
        chk("midrst_ovr",  ov_cnt - ov0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
